data_memory_arbiter: RTL and testbench

- Shares the single data_memory port between two requesters: port A (core load/store path) and port B (program loader / debug access).
- Serialises requests with round-robin priority and registers the winning command into the memory port.
- Captures read data and returns a one-cycle ack to the winner.
- Sits between the requesters and data_memory; data_memory writes on the clock edge and reads combinationally.

---
 rtl/data_memory_pkg.sv | 16 +
 rtl/rr_picker_2.sv | 16 +
 rtl/data_memory_arbiter.sv | 86 ++++++++
 tb/tb_data_memory_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_memory_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 64;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/rr_picker_2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_picker_2
   import data_memory_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       valid,
   output logic       winner
);

   always_comb begin
      valid  = |req;
      winner = (req == 2'b11) ? ~last_grant : req[REQ_B];
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Serialises port A and port B onto one data_memory port: IDLE -> ISSUE -> RESP, one access per 3 cycles.
module data_memory_arbiter
   import data_memory_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  a_req,
   input  logic                  a_write,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_ack,
   input  logic                  b_req,
   input  logic                  b_write,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_write,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   state_t                state;
   logic                  last_grant;
   logic                  grant_id;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  pick_valid;
   logic                  pick_id;

   rr_picker_2 u_picker (
      .req        ({b_req, a_req}),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .winner     (pick_id)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= REQ_B;
         grant_id   <= REQ_A;
         cmd_write  <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         rdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  cmd_write  <= (pick_id == REQ_B) ? b_write : a_write;
                  cmd_addr   <= (pick_id == REQ_B) ? b_addr  : a_addr;
                  cmd_wdata  <= (pick_id == REQ_B) ? b_wdata : a_wdata;
                  grant_id   <= pick_id;
                  last_grant <= pick_id;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (!cmd_write) rdata <= mem_read_data;
               state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are gated by reset_n so a write whose ISSUE cycle is cut short by
   // reset never reaches the memory on that same edge.
   always_comb begin
      mem_write      = reset_n && (state == ISSUE) && cmd_write;
      mem_read       = reset_n && (state == ISSUE) && !cmd_write;
      mem_address    = cmd_addr;
      mem_write_data = cmd_wdata;
      a_ack          = (state == RESP) && (grant_id == REQ_A);
      b_ack          = (state == RESP) && (grant_id == REQ_B);
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural data_memory (edge write, combinational read).
module tb_data_memory_arbiter;

   logic        clock;
   logic        reset_n;
   logic        a_req, a_write, b_req, b_write;
   logic [31:0] a_addr, b_addr;
   logic [63:0] a_wdata, b_wdata;
   logic        a_ack, b_ack;
   logic [63:0] rdata;
   logic        mem_write, mem_read;
   logic [31:0] mem_address;
   logic [63:0] mem_write_data, mem_read_data;

   logic [63:0] mem_arr [0:63];

   int tests = 0;
   int fails = 0;

   data_memory_arbiter dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .a_req          (a_req),
      .a_write        (a_write),
      .a_addr         (a_addr),
      .a_wdata        (a_wdata),
      .a_ack          (a_ack),
      .b_req          (b_req),
      .b_write        (b_write),
      .b_addr         (b_addr),
      .b_wdata        (b_wdata),
      .b_ack          (b_ack),
      .rdata          (rdata),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) if (mem_write) mem_arr[mem_address[5:0]] <= mem_write_data;
   assign mem_read_data = mem_arr[mem_address[5:0]];

   typedef struct {
      bit          port;
      bit          wr;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rd;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One access on one port from IDLE; returns to IDLE with the port released.
   task automatic do_access(input bit port, input bit wr, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [63:0] exp_rd);
      int lat = 0;
      bit got = 0;
      int nw = 0;
      int nr = 0;
      if (port) begin
         b_write = wr; b_addr = addr; b_wdata = wd; b_req = 1'b1;
      end else begin
         a_write = wr; a_addr = addr; a_wdata = wd; a_req = 1'b1;
      end
      for (int c = 1; c <= 8 && !got; c++) begin
         tick();
         if (mem_write) nw++;
         if (mem_read) nr++;
         if (mem_write || mem_read) begin
            check("mem_address", mem_address, addr);
            if (wr) check("mem_write_data", mem_write_data, wd);
         end
         if (port ? b_ack : a_ack) begin
            got = 1;
            lat = c;
            check("other_ack_low", port ? a_ack : b_ack, 0);
            check("rdata_at_ack", rdata, exp_rd);
         end
      end
      check("ack_seen", got, 1);
      check("ack_latency", lat, 2);
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
      check("ack_one_cycle", port ? b_ack : a_ack, 0);
      check("mem_write_pulses", nw, wr ? 1 : 0);
      check("mem_read_pulses", nr, wr ? 0 : 1);
   endtask

   initial begin
      bit          seq [$];
      int          overlap;
      reset_n = 1'b0;
      a_req = 0; a_write = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_write = 0; b_addr = 0; b_wdata = 0;

      vecs[0] = '{0, 1, 32'd0,  64'hAAAA_BBBB_CCCC_DDDD, 64'h0};
      vecs[1] = '{0, 0, 32'd0,  64'h0,                   64'hAAAA_BBBB_CCCC_DDDD};
      vecs[2] = '{1, 1, 32'd16, 64'h1616_1616_1616_1616, 64'hAAAA_BBBB_CCCC_DDDD};
      vecs[3] = '{1, 0, 32'd16, 64'h0,                   64'h1616_1616_1616_1616};

      tick(); tick();
      check("rst_a_ack", a_ack, 0);
      check("rst_b_ack", b_ack, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_write_data", mem_write_data, 0);
      check("rst_rdata", rdata, 0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 4; i++)
         do_access(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

      // Simultaneous requests straight after reset: A must win the tie.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      a_write = 1; a_addr = 32'd4; a_wdata = 64'h1234_5678_9ABC_DEF0; a_req = 1;
      b_write = 1; b_addr = 32'd8; b_wdata = 64'hDEAD_BEEF_0000_1111; b_req = 1;
      tick();
      check("tie_issue_addr", mem_address, 4);
      check("tie_issue_write", mem_write, 1);
      tick();
      check("tie_a_ack", a_ack, 1);
      check("tie_b_ack_low", b_ack, 0);
      a_req = 0;
      tick();
      tick();
      check("tie_b_issue_addr", mem_address, 8);
      check("tie_b_issue_data", mem_write_data, 64'hDEAD_BEEF_0000_1111);
      tick();
      check("tie_b_ack", b_ack, 1);
      check("tie_a_ack_low", a_ack, 0);
      b_req = 0;
      tick();
      do_access(0, 0, 32'd4, 64'h0, 64'h1234_5678_9ABC_DEF0);
      do_access(1, 0, 32'd8, 64'h0, 64'hDEAD_BEEF_0000_1111);

      // Continuous contention for 12 cycles: expect A,B,A,B.
      overlap = 0;
      a_write = 0; a_addr = 32'd4; a_req = 1;
      b_write = 0; b_addr = 32'd8; b_req = 1;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (mem_write && mem_read) overlap++;
         if (a_ack) begin
            seq.push_back(1'b0);
            check("fair_a_rdata", rdata, 64'h1234_5678_9ABC_DEF0);
         end
         if (b_ack) begin
            seq.push_back(1'b1);
            check("fair_b_rdata", rdata, 64'hDEAD_BEEF_0000_1111);
         end
      end
      a_req = 0; b_req = 0;
      check("fair_ack_count", seq.size(), 4);
      check("fair_overlap", overlap, 0);
      for (int k = 0; k < seq.size() && k < 4; k++)
         check("fair_order", seq[k], k % 2);
      tick(); tick(); tick();

      // Reset while a B write sits in ISSUE: it must not commit or ack.
      b_write = 1; b_addr = 32'd16; b_wdata = 64'h0BAD_0BAD_0BAD_0BAD; b_req = 1;
      tick();
      check("abort_in_issue", mem_write, 1);
      reset_n = 1'b0;
      #1;
      check("abort_write_gated", mem_write, 0);
      tick();
      reset_n = 1'b1;
      b_req = 0;
      check("abort_b_ack", b_ack, 0);
      check("abort_a_ack", a_ack, 0);
      check("abort_mem_write", mem_write, 0);
      check("abort_mem_read", mem_read, 0);
      check("abort_mem_address", mem_address, 0);
      check("abort_mem_write_data", mem_write_data, 0);
      check("abort_rdata", rdata, 0);
      tick();
      check("abort_no_late_ack", b_ack, 0);
      do_access(1, 0, 32'd16, 64'h0, 64'h1616_1616_1616_1616);

      // rdata must survive an intervening write.
      do_access(1, 0, 32'd8, 64'h0, 64'hDEAD_BEEF_0000_1111);
      do_access(0, 1, 32'd0, 64'h5555_5555_5555_5555, 64'hDEAD_BEEF_0000_1111);
      do_access(0, 0, 32'd0, 64'h0, 64'h5555_5555_5555_5555);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
